// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encodings, requester IDs and default widths for the memory arbiter.
package mem_arb_pkg;
  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, COMPLETE} state_t;
  typedef enum logic {REQ_CPU = 1'b0, REQ_DMA = 1'b1} req_id_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARB_ROUND_ROBIN_EN selects round robin over fixed CPU priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  req_id_t last,
`endif
  input  logic    cpu_req,
  input  logic    dma_req,
  output logic    any,
  output req_id_t win
);
  always_comb begin
    any = cpu_req | dma_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    win = (cpu_req && dma_req) ? (last == REQ_CPU ? REQ_DMA : REQ_CPU) : (cpu_req ? REQ_CPU : REQ_DMA);
`else
    win = cpu_req ? REQ_CPU : REQ_DMA;
`endif
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory between CPU and DMA, one registered transaction per 3 cycles (MEM_ARB_ROUND_ROBIN_EN: round robin).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_wr_enable,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);
  state_t  state, state_n;
  req_id_t owner, win;
  logic    any;
  mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last    (owner),
`endif
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .any     (any),
    .win     (win)
  );
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = state == IDLE ? (any ? ISSUE : IDLE) : state == ISSUE ? COMPLETE : IDLE;
  // owner doubles as the last-winner pointer; it resets to DMA so CPU wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      owner         <= REQ_DMA;
      cpu_gnt       <= 1'b0;
      dma_gnt       <= 1'b0;
      cpu_done      <= 1'b0;
      dma_done      <= 1'b0;
      cpu_rdata     <= '0;
      dma_rdata     <= '0;
      mem_enable    <= 1'b0;
      mem_wr_enable <= 1'b0;
      mem_address   <= '0;
      mem_wr_data   <= '0;
    end else begin
      cpu_gnt  <= 1'b0;
      dma_gnt  <= 1'b0;
      cpu_done <= 1'b0;
      dma_done <= 1'b0;
      if (state == IDLE && any) begin
        owner         <= win;
        cpu_gnt       <= win == REQ_CPU;
        dma_gnt       <= win == REQ_DMA;
        mem_enable    <= 1'b1;
        mem_wr_enable <= win == REQ_CPU ? cpu_wr : dma_wr;
        mem_address   <= win == REQ_CPU ? cpu_addr : dma_addr;
        mem_wr_data   <= win == REQ_CPU ? cpu_wdata : dma_wdata;
      end
      if (state == COMPLETE) begin
        cpu_done      <= owner == REQ_CPU;
        dma_done      <= owner == REQ_DMA;
        mem_enable    <= 1'b0;
        mem_wr_enable <= 1'b0;
        if (!mem_wr_enable && owner == REQ_CPU) cpu_rdata <= mem_rd_data;
        if (!mem_wr_enable && owner == REQ_DMA) dma_rdata <= mem_rd_data;
      end
    end
  end
endmodule
